// File: rtl/rhythm_game_sequencer.sv
// rhythm_game_sequencer
//  Run-state sequencer for the rhythm game: IDLE -> COUNTDOWN -> PLAY -> DONE.
//  Generates the beat divider, beat tick, map-load pulse and shift enable for the
//  rhythm-map datapath, and reports state / beats remaining for the display logic.
//  Optional feature macro: RHYTHM_PAUSE_EN (pause key support). When it is not
//  defined, pause_n is ignored and paused stays 0.
module rhythm_game_sequencer #(
  parameter int TICK_DIV    = 6250000,
  parameter int COUNT_BEATS = 24,
  parameter int SONG_BEATS  = 191,
  parameter int BEAT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_n,
  input  logic              pause_n,
  output logic [1:0]        state,
  output logic              load_map,
  output logic              beat_tick,
  output logic              shift_en,
  output logic              paused,
  output logic              game_over,
  output logic [BEAT_W-1:0] beats_left
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [BEAT_W-1:0] CNT_INIT  = BEAT_W'(COUNT_BEATS);
  localparam logic [BEAT_W-1:0] SONG_INIT = BEAT_W'(SONG_BEATS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_COUNT = 2'b01,
    S_PLAY  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t             state_reg;
  logic [DIV_W-1:0]   div_reg;
  logic [BEAT_W-1:0]  beats_left_reg;
  logic               load_map_reg;
  logic               beat_tick_reg;
  logic               shift_en_reg;
  logic               paused_reg;
  logic               game_over_reg;

  // Bit 0 is the metastability catcher, bit 1 the synced level, bit 2 the
  // previous synced level used for falling-edge (press) detection.
  logic [2:0] start_sync_reg;
  logic       start_ev;
  logic       pause_ev;

  // Start key synchroniser and press history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_sync_reg <= 3'b000;
    end else begin
      start_sync_reg <= {start_sync_reg[1:0], start_n};
    end
  end

  // A press is a synced 1->0 transition; holding the key gives one event only.
  assign start_ev = start_sync_reg[2] & ~start_sync_reg[1];

`ifdef RHYTHM_PAUSE_EN
  logic [2:0] pause_sync_reg;

  // Pause key synchroniser and press history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pause_sync_reg <= 3'b000;
    end else begin
      pause_sync_reg <= {pause_sync_reg[1:0], pause_n};
    end
  end

  assign pause_ev = pause_sync_reg[2] & ~pause_sync_reg[1];
`else
  // Pause key is not used in this build; keep the pin for a stable pinout.
  logic unused_pause_n;
  assign unused_pause_n = pause_n;
  assign pause_ev       = 1'b0;
`endif

  logic counting;
  logic tick;

  // Divider runs in COUNTDOWN and in unpaused PLAY; tick on the last count
  always_comb begin
    counting = (state_reg == S_COUNT) || ((state_reg == S_PLAY) && !paused_reg);
    tick     = counting && (div_reg == DIV_LAST);
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      div_reg        <= '0;
      beats_left_reg <= '0;
      load_map_reg   <= 1'b0;
      beat_tick_reg  <= 1'b0;
      shift_en_reg   <= 1'b0;
      paused_reg     <= 1'b0;
      game_over_reg  <= 1'b0;
    end else begin
      load_map_reg  <= 1'b0;
      beat_tick_reg <= 1'b0;
      if (start_ev) begin
        // Start has priority over a tick or a pause in the same cycle.
        div_reg       <= '0;
        paused_reg    <= 1'b0;
        shift_en_reg  <= 1'b0;
        game_over_reg <= 1'b0;
        if ((state_reg == S_IDLE) || (state_reg == S_DONE)) begin
          state_reg      <= S_COUNT;
          beats_left_reg <= CNT_INIT;
          load_map_reg   <= 1'b1;
        end else begin
          state_reg      <= S_IDLE;
          beats_left_reg <= '0;
        end
      end else begin
        case (state_reg)
          S_COUNT: begin
            if (tick) begin
              div_reg <= '0;
              if (beats_left_reg == BEAT_W'(1)) begin
                state_reg      <= S_PLAY;
                beats_left_reg <= SONG_INIT;
                shift_en_reg   <= 1'b1;
              end else begin
                beats_left_reg <= beats_left_reg - 1'b1;
              end
            end else begin
              div_reg <= div_reg + 1'b1;
            end
          end
          S_PLAY: begin
            if (tick) begin
              div_reg       <= '0;
              beat_tick_reg <= 1'b1;
            end else if (counting) begin
              div_reg <= div_reg + 1'b1;
            end
            if (tick && (beats_left_reg == BEAT_W'(1))) begin
              // Last beat of the song: leave PLAY, which also drops pause.
              state_reg      <= S_DONE;
              beats_left_reg <= '0;
              shift_en_reg   <= 1'b0;
              paused_reg     <= 1'b0;
              game_over_reg  <= 1'b1;
            end else begin
              if (tick) begin
                beats_left_reg <= beats_left_reg - 1'b1;
              end
              if (pause_ev) begin
                paused_reg   <= ~paused_reg;
                shift_en_reg <= paused_reg;
              end
            end
          end
          default: begin
            // IDLE and DONE wait for a start press; nothing counts.
            div_reg <= '0;
          end
        endcase
      end
    end
  end

  assign state      = state_reg;
  assign load_map   = load_map_reg;
  assign beat_tick  = beat_tick_reg;
  assign shift_en   = shift_en_reg;
  assign paused     = paused_reg;
  assign game_over  = game_over_reg;
  assign beats_left = beats_left_reg;

endmodule

// File: tb/tb_rhythm_game_sequencer.sv
// Testbench for rhythm_game_sequencer: directed scenarios with literal
// expectations plus randomized key/reset activity checked every cycle against
// a behavioural model of the game rules.
module tb_rhythm_game_sequencer;

  localparam int TD = 4;
  localparam int CB = 2;
  localparam int SB = 3;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_n = 1'b1;
  logic          pause_n = 1'b1;
  logic [1:0]    state;
  logic          load_map;
  logic          beat_tick;
  logic          shift_en;
  logic          paused;
  logic          game_over;
  logic [BW-1:0] beats_left;

  int checks = 0;
  int errors = 0;

  rhythm_game_sequencer #(
    .TICK_DIV(TD), .COUNT_BEATS(CB), .SONG_BEATS(SB), .BEAT_W(BW)
  ) dut (
    .clk(clk), .rst(rst), .start_n(start_n), .pause_n(pause_n),
    .state(state), .load_map(load_map), .beat_tick(beat_tick),
    .shift_en(shift_en), .paused(paused), .game_over(game_over),
    .beats_left(beats_left)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 idle, 1 countdown, 2 play, 3 done.
  logic [3:0] hs;
`ifdef RHYTHM_PAUSE_EN
  logic [3:0] hp;
`endif
  int m_mode, m_bl, m_phase;
  bit m_paused, m_load, m_beat;

  task automatic model_reset();
    hs = 4'b0;
`ifdef RHYTHM_PAUSE_EN
    hp = 4'b0;
`endif
    m_mode = 0; m_bl = 0; m_phase = 0;
    m_paused = 0; m_load = 0; m_beat = 0;
  endtask

  // One clock edge of the game rules. Key samples are kept as a history; a
  // press takes effect two edges after the pin was first seen low.
  task automatic model_step();
    bit ev_s, ev_p, cnt, tk;
    hs = {hs[2:0], start_n};
    ev_s = hs[3] & ~hs[2];
`ifdef RHYTHM_PAUSE_EN
    hp = {hp[2:0], pause_n};
    ev_p = hp[3] & ~hp[2];
`else
    ev_p = 1'b0;
`endif
    m_load = 0;
    m_beat = 0;
    cnt = (m_mode == 1) || (m_mode == 2 && !m_paused);
    tk  = cnt && (m_phase == TD - 1);
    if (ev_s) begin
      if (m_mode == 0 || m_mode == 3) begin
        m_mode = 1; m_bl = CB; m_load = 1;
      end else begin
        m_mode = 0; m_bl = 0;
      end
      m_phase = 0;
      m_paused = 0;
    end else begin
      if (ev_p && m_mode == 2) m_paused = !m_paused;
      if (cnt) m_phase = (m_phase + 1) % TD;
      if (tk) begin
        if (m_mode == 2) m_beat = 1;
        m_bl = m_bl - 1;
        if (m_bl == 0) begin
          if (m_mode == 1) begin
            m_mode = 2; m_bl = SB;
          end else begin
            m_mode = 3;
          end
          m_phase = 0;
          m_paused = 0;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] dut_vec();
    return {state, load_map, beat_tick, shift_en, paused, game_over, beats_left};
  endfunction

  function automatic logic [14:0] model_vec();
    logic [1:0] ms;
    ms = m_mode[1:0];
    return {ms, m_load, m_beat, (m_mode == 2) && !m_paused, m_paused,
            m_mode == 3, m_bl[BW-1:0]};
  endfunction

  // Advance one clock, update the model, then compare all outputs.
  task automatic cyc();
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    #1;
    check("cycle", {17'b0, dut_vec()}, {17'b0, model_vec()});
  endtask

  task automatic press_start();
    start_n = 1'b0; cyc(); start_n = 1'b1; cyc(); cyc();
  endtask

  task automatic press_pause();
    pause_n = 1'b0; cyc(); pause_n = 1'b1; cyc(); cyc();
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget);
    int n;
    n = 0;
    while (state !== s && n < budget) begin
      cyc();
      n++;
    end
    if (state !== s) begin
      errors++;
      $display("FAIL wait_state: state %0d never reached, still %0d", s, state);
    end
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    check("async_rst_outputs", {17'b0, dut_vec()}, 32'd0);
    model_reset();
    cyc();
    #2 rst = 1'b1;
  endtask

  initial begin
    int bt_count, held_bl, s_hold, p_hold;
    model_reset();
    repeat (3) cyc();
    #2 rst = 1'b1;

    // 1: idle after reset
    repeat (50) cyc();
    check("idle_state", state, 0);
    check("idle_beats", beats_left, 0);

    // 2: start -> countdown -> play
    press_start();
    check("cd_state", state, 1);
    check("cd_load", load_map, 1);
    check("cd_beats", beats_left, 2);
    cyc();
    check("load_one_cycle", load_map, 0);
    repeat (7) cyc();
    check("play_state", state, 2);
    check("play_beats", beats_left, 3);
    check("play_shift", shift_en, 1);

    // 3: song runs to done, then restart
    bt_count = 0;
    repeat (12) begin
      cyc();
      if (beat_tick) bt_count++;
    end
    check("beat_ticks", bt_count, 3);
    check("done_state", state, 3);
    check("done_game_over", game_over, 1);
    check("done_shift", shift_en, 0);
    check("done_beats", beats_left, 0);
    press_start();
    check("restart_state", state, 1);
    check("restart_load", load_map, 1);

    // 4: pause in play
    wait_state(2'd2, 20);
`ifdef RHYTHM_PAUSE_EN
    press_pause();
    check("paused_flag", paused, 1);
    check("paused_shift", shift_en, 0);
    held_bl = beats_left;
    bt_count = 0;
    repeat (20) begin
      cyc();
      if (beat_tick) bt_count++;
    end
    check("paused_no_tick", bt_count, 0);
    check("paused_beats_held", beats_left, held_bl);
    press_pause();
    check("resumed_flag", paused, 0);
    check("resumed_shift", shift_en, 1);
    cyc();
    check("resume_partial_tick", beat_tick, 1);
    check("resume_beats", beats_left, 2);
`else
    press_pause();
    check("nopause_flag", paused, 0);
    check("nopause_shift", shift_en, 1);
`endif

    // 5: start and pause events together in play
    wait_state(2'd2, 40);
    start_n = 1'b0; pause_n = 1'b0; cyc();
    start_n = 1'b1; pause_n = 1'b1; cyc(); cyc();
    check("abort_state", state, 0);
    check("abort_paused", paused, 0);
    check("abort_beats", beats_left, 0);

    // 6: reset in the middle of countdown
    press_start();
    cyc(); cyc();
    async_reset();
    repeat (5) cyc();
    check("post_rst_state", state, 0);

    // Randomized key presses, holds and occasional resets
    s_hold = 0;
    p_hold = 0;
    for (int i = 0; i < 5000; i++) begin
      if (s_hold == 0 && $urandom_range(0, 99) < 2) s_hold = $urandom_range(1, 6);
      if (p_hold == 0 && $urandom_range(0, 99) < 6) p_hold = $urandom_range(1, 4);
      start_n = (s_hold > 0) ? 1'b0 : 1'b1;
      pause_n = (p_hold > 0) ? 1'b0 : 1'b1;
      if (s_hold > 0) s_hold--;
      if (p_hold > 0) p_hold--;
      if ($urandom_range(0, 999) < 2) async_reset();
      else cyc();
    end
    start_n = 1'b1;
    pause_n = 1'b1;
    repeat (4) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
